nios_onchip_mem_tester: RTL and testbench
=========================================

# nios_onchip_mem_tester

Avalon-MM master that drives the single-port on-chip memory slave (10-bit word address, 32-bit data, 4 byte lanes, one-cycle read latency) through a full write-then-verify pass. It fills every word with an address-derived pattern, reads every word back, and flags mismatches. It sits beside the NIOS II system as a power-on or debug self-test engine for the on-chip RAM. It connects directly to the memory's `address`/`byteenable`/`chipselect`/`write`/`writedata`/`readdata`/`clken` pins, and only while the CPU is held off that port.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width.
- `DEPTH`, 1024: number of words tested, ≤ 2^ADDR_W.

Ports:
- `clk` in 1: single clock, the same clock as the memory.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `abort` in 1: terminates any active pass.
- `seed` in 32: pattern seed, latched on accepted `start`.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at the end of a completed (not aborted) pass.
- `error` out 1: sticky mismatch flag; cleared on accepted `start`.
- `err_count` out ADDR_W+1: number of mismatching words, saturating.
- `err_addr` out ADDR_W: address of the first mismatch.
- `err_data` out 32: readdata captured at the first mismatch.
- `mem_address` out ADDR_W, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_clken` out 1: master side of the memory port.
- `mem_readdata` in 32: returned data, valid one cycle after the read address is presented.

## Operation
- Pattern: `P(a) = seed_q ^ {6'b0, a, 6'b0, a}` for ADDR_W=10. For other widths, zero-extend `a` to 16 bits in each half.
- FSM states: IDLE, FILL, VERIFY, DRAIN, DONE.
- **IDLE**:
  - `start`=1 and `abort`=0 → FILL. The same edge latches `seed_q`, zeroes the address counter, and clears `error`/`err_count`/`err_addr`/`err_data`.
- **FILL**:
  - Each cycle: `mem_chipselect`=1, `mem_write`=1, `mem_byteenable`=4'hF, `mem_address`=cnt, `mem_writedata`=P(cnt).
  - cnt increments each cycle.
  - After writing cnt=DEPTH-1: cnt wraps to 0 → VERIFY.
- **VERIFY**:
  - Each cycle: `mem_chipselect`=1, `mem_write`=0, `mem_address`=cnt.
  - Register `cmp_valid`=1 and `cmp_addr`=cnt for the following cycle.
  - After issuing cnt=DEPTH-1 → DRAIN.
- **DRAIN**:
  - One cycle, no bus access. Performs the final compare.
  - → DONE.
- **Compare**: whenever `cmp_valid`=1, check `mem_readdata` against P(`cmp_addr`). On mismatch:
  - set `error`;
  - `err_count`+1, saturating at all-ones;
  - if this is the first mismatch of the pass, capture `err_addr`=`cmp_addr` and `err_data`=`mem_readdata`.
- **DONE**: `done`=1 for one cycle → IDLE.
- **abort**: in FILL, VERIFY or DRAIN → IDLE on the next edge.
  - No `done` pulse.
  - The in-flight compare is discarded.
  - Error state is retained.
- `start` outside IDLE is ignored.
- `abort` in IDLE or DONE has no effect.
- `mem_clken`=1 whenever `reset_n`=1.
- Outside FILL and VERIFY: `mem_chipselect`=0 and `mem_write`=0.

## Timing
- Reset values (asynchronous): state IDLE, all outputs 0, including `mem_clken`, `mem_*`, `busy`, `done`, `error`, `err_count`, `err_addr`, `err_data`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `start` accepted at edge T:
  - writes occur in cycles T+1 … T+DEPTH;
  - reads are issued in cycles T+DEPTH+1 … T+2·DEPTH;
  - compares happen in cycles T+DEPTH+2 … T+2·DEPTH+1;
  - `done` is high in cycle T+2·DEPTH+2.
- `busy` is high from cycle T+1 through T+2·DEPTH+1 and is low in the `done` cycle.
- The first read, of address 0, immediately follows the last write, of address DEPTH-1. No turnaround cycle is inserted.
- `start` in the same cycle as `done` is ignored. The earliest restart is the cycle after `done`.

## Configuration
- Macro: `MEMTEST_ERR_LOG_EN`.
- Defined: `err_count`, `err_addr` and `err_data` behave as specified above.
- Undefined: that logging logic is not built. `err_count`, `err_addr` and `err_data` are tied to 0. `error`, `busy`, `done` and the bus behaviour are unchanged.

## Test plan
- **Clean pass**: DEPTH=1024, seed=0, ideal memory model, `start` at T.
  - Write at address 5 carries 0x00050005.
  - `done` high at T+2050.
  - `error`=0, `err_count`=0.
- **Seeded pattern**: seed=0xA5A5A5A5.
  - Write at address 5 carries 0xA5A0A5A0.
  - Readback of all 1024 words matches; `error`=0.
- **Fault injection** (macro defined): the model flips bit 0 of readdata at address 0x3FF.
  - `error`=1, `err_count`=1, `err_addr`=0x3FF, `err_data`=0x03FF03FE.
- **Stuck-at fault**: the model returns 0 for addresses 0x010 and 0x020.
  - `err_count`=2, `err_addr`=0x010, `err_data`=0.
  - Next `start` clears all error state.
- **Abort in VERIFY** at the 100th read:
  - next cycle: `busy`=0, `mem_chipselect`=0, no `done` pulse;
  - a new `start` runs a full clean pass.
- **Reset mid-FILL**: assert `reset_n`=0 asynchronously.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - `start` after release produces a normal pass.

Source files
------------

// File: rtl/nios_onchip_mem_tester.sv
// Avalon-MM write-then-verify self-test master for the single-port on-chip RAM.
// Define MEMTEST_ERR_LOG_EN to build err_count/err_addr/err_data logging; otherwise they read 0.
module nios_onchip_mem_tester #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [31:0]       err_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Address zero-extended to 16 bits and replicated into both halves before the seed XOR.
    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [ADDR_W-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        return s ^ {a16, a16};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [31:0]       seed_q, seed_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [3:0]        mem_byteenable_q, mem_byteenable_d;
    logic              mem_chipselect_q, mem_chipselect_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_writedata_q, mem_writedata_d;
    logic              mem_clken_q, mem_clken_d;
    logic              active, aborting, clear_err, mismatch;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        cmp_valid_d = 1'b0;
        cmp_addr_d  = cnt_q;
        clear_err   = 1'b0;
        active      = (state_q == S_FILL) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
        aborting    = active && abort;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_FILL;
                    cnt_d     = '0;
                    seed_d    = seed;
                    clear_err = 1'b1;
                end
            end
            S_FILL: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_VERIFY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VERIFY: begin
                cmp_valid_d = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the read still in flight so it never reaches the comparator.
        if (aborting) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            cmp_valid_d = 1'b0;
        end

        mismatch = cmp_valid_q && !aborting && (mem_readdata != pattern(seed_q, cmp_addr_q));
        error_d  = clear_err ? 1'b0 : (error_q || mismatch);

        // Outputs are registered from the next-state view so the bus lines up with state_q.
        busy_d           = (state_d == S_FILL) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
        done_d           = (state_d == S_DONE);
        mem_chipselect_d = (state_d == S_FILL) || (state_d == S_VERIFY);
        mem_write_d      = (state_d == S_FILL);
        mem_byteenable_d = mem_chipselect_d ? 4'hF : 4'h0;
        mem_address_d    = mem_chipselect_d ? cnt_d : '0;
        mem_writedata_d  = mem_write_d ? pattern(seed_d, cnt_d) : 32'h0;
        mem_clken_d      = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            cmp_addr_q       <= '0;
            seed_q           <= '0;
            cmp_valid_q      <= 1'b0;
            error_q          <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_clken_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cmp_addr_q       <= cmp_addr_d;
            seed_q           <= seed_d;
            cmp_valid_q      <= cmp_valid_d;
            error_q          <= error_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_clken_q      <= mem_clken_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = mem_clken_q;

`ifdef MEMTEST_ERR_LOG_EN
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [31:0]       err_data_q, err_data_d;

    // error_q still low means this is the first mismatch of the pass.
    always_comb begin
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        if (clear_err) begin
            err_count_d = '0;
            err_addr_d  = '0;
            err_data_d  = '0;
        end else if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (!error_q) begin
                err_addr_d = cmp_addr_q;
                err_data_d = mem_readdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;
`else
    assign err_count = '0;
    assign err_addr  = '0;
    assign err_data  = '0;
`endif

endmodule

// File: tb/tb_nios_onchip_mem_tester.sv
// Scoreboard bench for nios_onchip_mem_tester: stimulus queues expected bus traffic and pass
// results; falling-edge monitors pop and compare whenever the DUT writes, reads or pulses done.
module tb_nios_onchip_mem_tester;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
`ifdef MEMTEST_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] err_count;
    logic [9:0]  err_addr;
    logic [31:0] err_data;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    nios_onchip_mem_tester #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_count      (err_count),
        .err_addr       (err_addr),
        .err_data       (err_data),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [9:0] addr; logic [31:0] data; int off; } wr_exp_t;
    typedef struct { logic [9:0] addr; int off; } rd_exp_t;
    typedef struct { logic err; logic [10:0] cnt; logic [9:0] ea; logic [31:0] ed; } res_exp_t;

    wr_exp_t  wq[$];
    rd_exp_t  rq[$];
    res_exp_t resq[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          start_edge = 0;
    int          done_seen = 0;
    int          pass_no = 0;
    int          fault_mode = 0;
    bit          spot_en = 1'b0;
    logic [9:0]  spot_addr = 10'd5;
    logic [31:0] spot_data = 32'h0;

    // Ideal one-cycle-latency RAM with optional read-side fault injection.
    logic [31:0] mem [0:DEPTH-1];

    function automatic logic [31:0] read_model(input logic [9:0] a);
        logic [31:0] v;
        v = mem[a];
        if (fault_mode == 1 && a == 10'h3FF) v = v ^ 32'h1;
        if (fault_mode == 2 && (a == 10'h010 || a == 10'h020)) v = 32'h0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= read_model(mem_address);
            end
        end
    end

    function automatic logic [31:0] pat(input logic [31:0] s, input logic [9:0] a);
        return s ^ {6'b0, a, 6'b0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) $display("FAIL %s: got %h expected %h", name, act, want);
        else n_pass++;
    endtask

    task automatic push_pass(input logic [31:0] s);
        for (int a = 0; a < DEPTH; a++) begin
            wq.push_back('{10'(a), pat(s, 10'(a)), a});
            rq.push_back('{10'(a), DEPTH + a});
        end
    endtask

    task automatic push_res(input logic e, input logic [10:0] c, input logic [9:0] ea,
                            input logic [31:0] ed);
        resq.push_back('{e, c, ea, ed});
    endtask

    task automatic start_pass(input logic [31:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        start = 1'b0;
        pass_no++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (resq.size() != 0 && n < 3 * DEPTH) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pass_complete", 64'(resq.size()), 64'd0);
        check("wr_drained", 64'(wq.size()), 64'd0);
        check("rd_drained", 64'(rq.size()), 64'd0);
        resq.delete();
        wq.delete();
        rq.delete();
    endtask

    task automatic wait_offset(input int off);
        int n;
        n = 0;
        while (cyc - start_edge < off && n < 3 * DEPTH) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_done"}, 64'(done), 64'd0);
        check({p, "_error"}, 64'(error), 64'd0);
        check({p, "_err_count"}, 64'(err_count), 64'd0);
        check({p, "_err_addr"}, 64'(err_addr), 64'd0);
        check({p, "_err_data"}, 64'(err_data), 64'd0);
        check({p, "_address"}, 64'(mem_address), 64'd0);
        check({p, "_byteenable"}, 64'(mem_byteenable), 64'd0);
        check({p, "_chipselect"}, 64'(mem_chipselect), 64'd0);
        check({p, "_write"}, 64'(mem_write), 64'd0);
        check({p, "_writedata"}, 64'(mem_writedata), 64'd0);
        check({p, "_clken"}, 64'(mem_clken), 64'd0);
    endtask

    // Write monitor: address/data/lanes/busy plus the cycle offset from the accepting edge.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_chipselect && mem_write) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 64'(mem_write), 64'd0);
                end else begin
                    e = wq.pop_front();
                    check("wr", {17'b0, busy, mem_byteenable, mem_address, mem_writedata},
                          {17'b0, 1'b1, 4'hF, e.addr, e.data});
                    check("wr_cycle", 64'(cyc - start_edge), 64'(e.off));
                    if (spot_en && mem_address == spot_addr)
                        check("wr_spot", 64'(mem_writedata), 64'(spot_data));
                end
            end
        end
    end

    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_chipselect && !mem_write) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 64'(mem_chipselect), 64'd0);
                end else begin
                    e = rq.pop_front();
                    check("rd", 64'({busy, mem_address}), 64'({1'b1, e.addr}));
                    check("rd_cycle", 64'(cyc - start_edge), 64'(e.off));
                end
            end
        end
    end

    initial begin
        res_exp_t r;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                done_seen++;
                if (resq.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    r = resq.pop_front();
                    check("done_cycle", 64'(cyc - start_edge), 64'(2 * DEPTH + 1));
                    check("done_busy", 64'(busy), 64'd0);
                    check("error", 64'(error), 64'(r.err));
                    check("err_count", 64'(err_count), 64'(r.cnt));
                    check("err_addr", 64'(err_addr), 64'(r.ea));
                    check("err_data", 64'(err_data), 64'(r.ed));
                    $display("pass %0d done: seed=%h error=%0d err_count=%0d err_addr=%h err_data=%h",
                             pass_no, seed, error, err_count, err_addr, err_data);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("clken_after_reset", 64'(mem_clken), 64'd1);
        $display("reset: outputs checked");

        // Clean pass, seed 0: address 5 carries 0x00050005.
        fault_mode = 0;
        spot_en = 1'b1;
        spot_data = 32'h00050005;
        push_pass(32'h0);
        push_res(1'b0, 11'd0, 10'd0, 32'h0);
        start_pass(32'h0);
        wait_done();

        // Seeded pass; start held during the done cycle must be ignored.
        spot_data = 32'hA5A0A5A0;
        push_pass(32'hA5A5A5A5);
        push_res(1'b0, 11'd0, 10'd0, 32'h0);
        start_pass(32'hA5A5A5A5);
        wait_offset(2 * DEPTH + 1);
        check("done_cycle_seen", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_busy", 64'(busy), 64'd0);
        check("start_in_done_cs", 64'(mem_chipselect), 64'd0);
        $display("start during done: busy=%0d", busy);
        wait_done();
        spot_en = 1'b0;

        // Bit 0 flipped on readback of 0x3FF.
        fault_mode = 1;
        push_pass(32'h0);
        push_res(1'b1, LOG_EN ? 11'd1 : 11'd0, LOG_EN ? 10'h3FF : 10'h0,
                 LOG_EN ? 32'h03FF03FE : 32'h0);
        start_pass(32'h0);
        wait_done();

        // Stuck-at-zero at 0x010 and 0x020, then a clean pass that clears the error state.
        fault_mode = 2;
        push_pass(32'h0);
        push_res(1'b1, LOG_EN ? 11'd2 : 11'd0, LOG_EN ? 10'h010 : 10'h0, 32'h0);
        start_pass(32'h0);
        wait_done();
        fault_mode = 0;
        push_pass(32'h0);
        push_res(1'b0, 11'd0, 10'd0, 32'h0);
        start_pass(32'h0);
        check("clr_error", 64'(error), 64'd0);
        check("clr_err_count", 64'(err_count), 64'd0);
        check("clr_err_addr", 64'(err_addr), 64'd0);
        check("clr_err_data", 64'(err_data), 64'd0);
        wait_done();

        // Abort while the 100th read (address 99) is on the bus.
        push_pass(32'h0);
        start_pass(32'h0);
        wait_offset(DEPTH + 99);
        check("abort_at_read99", 64'(mem_address), 64'd99);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_chipselect", 64'(mem_chipselect), 64'd0);
        check("abort_write", 64'(mem_write), 64'd0);
        check("abort_reads_left", 64'(rq.size()), 64'(DEPTH - 100));
        wq.delete();
        rq.delete();
        d0 = done_seen;
        repeat (4) @(negedge clk);
        #1;
        check("abort_no_done", 64'(done_seen), 64'(d0));
        check("abort_error_kept", 64'(error), 64'd0);
        $display("abort: busy=%0d chipselect=%0d", busy, mem_chipselect);
        push_pass(32'h0);
        push_res(1'b0, 11'd0, 10'd0, 32'h0);
        start_pass(32'h0);
        wait_done();

        // Asynchronous reset in the middle of FILL, between clock edges.
        push_pass(32'h12345678);
        start_pass(32'h12345678);
        repeat (50) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midfill");
        $display("reset mid-fill: busy=%0d chipselect=%0d", busy, mem_chipselect);
        wq.delete();
        rq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_pass(32'h12345678);
        push_res(1'b0, 11'd0, 10'd0, 32'h0);
        start_pass(32'h12345678);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
